// File: rtl/ucsbece154b_icache_pkg.sv
// Shared types and address-field helpers for the set-associative instruction cache.
package ucsbece154b_icache_pkg;

  typedef enum logic [1:0] {StIdle, StMissReq, StRefill} state_t;

  function automatic int unsigned set_w(int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned woff_w(int unsigned blk);
    return $clog2(blk);
  endfunction

  // A direct-mapped build still needs a 1-bit way index.
  function automatic int unsigned way_w(int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int unsigned tag_w(int unsigned addr_w, int unsigned sets, int unsigned blk);
    return addr_w - 2 - $clog2(blk) - $clog2(sets);
  endfunction

  function automatic logic [63:0] addr_woff(logic [63:0] a, int unsigned blk);
    return (a >> 2) & 64'(blk - 1);
  endfunction

  function automatic logic [63:0] addr_set(logic [63:0] a, int unsigned blk, int unsigned sets);
    return (a >> (2 + $clog2(blk))) & 64'(sets - 1);
  endfunction

  function automatic logic [63:0] addr_tag(logic [63:0] a, int unsigned blk, int unsigned sets);
    return a >> (2 + $clog2(blk) + $clog2(sets));
  endfunction

endpackage

// File: rtl/ucsbece154b_icache_assoc_if.sv
// Fetch-side and refill-side signals of the instruction cache.
interface ucsbece154b_icache_assoc_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              ReadEnable;
  logic [ADDR_W-1:0] ReadAddress;
  logic [31:0]       Instruction;
  logic              Ready;
  logic              Misprediction;
  logic              Busy;
  logic [ADDR_W-1:0] MemReadAddress;
  logic              MemReadRequest;
  logic [31:0]       MemDataIn;
  logic              MemDataReady;

  modport slave (
    input  ReadEnable, ReadAddress, Misprediction, MemDataIn, MemDataReady,
    output Instruction, Ready, Busy, MemReadAddress, MemReadRequest
  );

  modport master (
    output ReadEnable, ReadAddress, Misprediction, MemDataIn, MemDataReady,
    input  Instruction, Ready, Busy, MemReadAddress, MemReadRequest
  );
endinterface

// File: rtl/ucsbece154b_icache_victim.sv
// Victim selection: lowest invalid way, otherwise a per-set round-robin pointer.
module ucsbece154b_icache_victim
  import ucsbece154b_icache_pkg::*;
#(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned NUM_WAYS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [set_w(NUM_SETS)-1:0]  set_idx_i,
  input  logic [NUM_WAYS-1:0]         valid_vec_i,
  input  logic                        fill_done_i,
  output logic [way_w(NUM_WAYS)-1:0]  victim_o
);
  localparam int unsigned WAY_W = way_w(NUM_WAYS);

  logic [WAY_W-1:0] rr_q [NUM_SETS];

  always_comb begin
    victim_o = rr_q[set_idx_i];
    // Descending scan so the lowest invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_vec_i[w]) victim_o = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
    end else if (fill_done_i) begin
      rr_q[set_idx_i] <= (rr_q[set_idx_i] == WAY_W'(NUM_WAYS - 1)) ? '0
                                                                 : rr_q[set_idx_i] + WAY_W'(1);
    end
  end
endmodule

// File: rtl/ucsbece154b_icache_assoc.sv
// N-way set-associative instruction cache with burst refill and early restart.
module ucsbece154b_icache_assoc
  import ucsbece154b_icache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 8,
  parameter int unsigned NUM_WAYS    = 4,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned ADDR_W      = 32
) (
  input logic                     clk,
  input logic                     reset,
  ucsbece154b_icache_assoc_if.slave bus
);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, NUM_SETS, BLOCK_WORDS);
  localparam int unsigned SET_W  = set_w(NUM_SETS);
  localparam int unsigned WOFF_W = woff_w(BLOCK_WORDS);
  localparam int unsigned WAY_W  = way_w(NUM_WAYS);

  logic [TAG_W-1:0]    tag_arr  [NUM_SETS][NUM_WAYS];
  logic [31:0]         data_arr [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] miss_addr_q;
  logic [WOFF_W-1:0] beat_q;
  logic              abort_q, ready_q;
  logic [31:0]       instr_q;

  logic [SET_W-1:0]    req_set, miss_set;
  logic [TAG_W-1:0]    req_tag, miss_tag;
  logic [WOFF_W-1:0]   req_woff, miss_woff;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit, lookup, busy, beat_fire, last_beat, early;
  logic [31:0]         hit_word;
  logic [WAY_W-1:0]    victim;

  assign req_set   = SET_W'(addr_set(64'(bus.ReadAddress), BLOCK_WORDS, NUM_SETS));
  assign req_tag   = TAG_W'(addr_tag(64'(bus.ReadAddress), BLOCK_WORDS, NUM_SETS));
  assign req_woff  = WOFF_W'(addr_woff(64'(bus.ReadAddress), BLOCK_WORDS));
  assign miss_set  = SET_W'(addr_set(64'(miss_addr_q), BLOCK_WORDS, NUM_SETS));
  assign miss_tag  = TAG_W'(addr_tag(64'(miss_addr_q), BLOCK_WORDS, NUM_SETS));
  assign miss_woff = WOFF_W'(addr_woff(64'(miss_addr_q), BLOCK_WORDS));

  always_comb begin
    hit_vec  = '0;
    hit_word = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_set][w] && (tag_arr[req_set][w] == req_tag)) begin
        hit_vec[w] = 1'b1;
        hit_word   = data_arr[req_set][w][req_woff];
      end
    end
  end

  assign hit       = |hit_vec;
  assign busy      = (state_q != StIdle);
  assign lookup    = (state_q == StIdle) && bus.ReadEnable && !bus.Misprediction;
  assign beat_fire = (state_q == StRefill) && bus.MemDataReady;
  assign last_beat = beat_fire && (beat_q == WOFF_W'(BLOCK_WORDS - 1));
  // Forward the requested word as it streams in unless a redirect killed it.
  assign early     = beat_fire && (beat_q == miss_woff) && !abort_q && !bus.Misprediction;

  ucsbece154b_icache_victim #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_victim (
    .clk         (clk),
    .reset       (reset),
    .set_idx_i   (miss_set),
    .valid_vec_i (valid_q[miss_set]),
    .fill_done_i (last_beat),
    .victim_o    (victim)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (lookup && !hit) state_d = StMissReq;
      StMissReq: state_d = StRefill;
      StRefill:  if (last_beat) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      beat_q      <= '0;
      abort_q     <= 1'b0;
      ready_q     <= 1'b0;
      instr_q     <= '0;
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= lookup && hit;
      if (lookup && hit)  instr_q <= hit_word;
      else if (early)     instr_q <= bus.MemDataIn;
      if (lookup && !hit) begin
        miss_addr_q <= bus.ReadAddress;
        abort_q     <= 1'b0;
      end
      if (busy && bus.Misprediction) abort_q <= 1'b1;
      if (beat_fire) beat_q <= beat_q + WOFF_W'(1);
      if (last_beat) valid_q[miss_set][victim] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire) data_arr[miss_set][victim][beat_q] <= bus.MemDataIn;
    if (last_beat) tag_arr[miss_set][victim] <= miss_tag;
  end

  always_ff @(posedge clk) begin
    if (!reset && lookup) assert ($onehot0(hit_vec));
  end

  assign bus.Ready          = ready_q || early;
  assign bus.Instruction    = early ? bus.MemDataIn : instr_q;
  assign bus.Busy           = busy;
  assign bus.MemReadRequest = (state_q == StMissReq);
  assign bus.MemReadAddress = miss_addr_q & ~ADDR_W'(BLOCK_WORDS * 4 - 1);
endmodule
